// File: rtl/screen_pkg.sv
// Shared screen definitions for the OLED front end.
// Holds the 4-bit screen codes, the loading sequencer FSM state type and the
// geometry of the loading bar drawn by the pixel generator.
package screen_pkg;

    // Screen codes driven on the top-level screen bus
    localparam logic [3:0] SCR_MENU     = 4'b0000;
    localparam logic [3:0] SCR_SETTINGS = 4'b0001;
    localparam logic [3:0] SCR_GAME     = 4'b0010;
    localparam logic [3:0] SCR_SCORES   = 4'b0011;
    localparam logic [3:0] SCR_LOADING  = 4'b0110;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StHold,
        StDone
    } seq_state_e;

    // loading_bar_geom: bar starts at X=15 and covers rows 30..37
    localparam int unsigned BAR_ORIGIN_X = 15;
    localparam int unsigned BAR_Y_TOP    = 30;
    localparam int unsigned BAR_Y_BOT    = 37;

endpackage

// File: rtl/loading_sequencer_if.sv
// Handshake/status bundle between the top-level screen logic (master) and the
// loading sequencer (slave).
//   start/target/skip : requests from the screen logic
//   screen            : current screen code
//   reveal/bar_len    : animation counters for the loading-screen renderer
//   busy/done         : sequencer status, done is a one-cycle hand-off pulse
interface loading_sequencer_if;
    logic       start;
    logic [3:0] target;
    logic       skip;
    logic [3:0] screen;
    logic [3:0] reveal;
    logic [5:0] bar_len;
    logic       busy;
    logic       done;

    modport master (
        output start, target, skip,
        input  screen, reveal, bar_len, busy, done
    );

    modport slave (
        input  start, target, skip,
        output screen, reveal, bar_len, busy, done
    );
endinterface

// File: rtl/tick_divider.sv
// Animation tick prescaler.
//   clk, reset : clock and synchronous active-high reset
//   clear      : forces the count back to 0
//   en         : count enable
//   tick       : one-cycle pulse while enabled and the count is at DIV-1
module tick_divider #(
    parameter int unsigned DIV = 625_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = en && (cnt_q == CntLast);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/loading_sequencer.sv
// Loading-screen sequencer. Accepts a start request, shows the loading screen
// while stepping the letter-reveal and progress-bar counters on the animation
// tick, holds the full bar for a while, then switches to the requested screen.
//   clk, reset : clock and synchronous active-high reset
//   bus        : loading_sequencer_if.slave (requests in, screen/counters/status out)
module loading_sequencer
    import screen_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 625_000,
    parameter int unsigned REVEAL_MAX = 9,
    parameter int unsigned BAR_STEP   = 12,
    parameter int unsigned BAR_MAX    = 60,
    parameter int unsigned HOLD_TICKS = 5
) (
    input logic                clk,
    input logic                reset,
    loading_sequencer_if.slave bus
);
    localparam int unsigned HoldW     = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [3:0]  RevealMax = 4'(REVEAL_MAX);
    localparam logic [5:0]  BarStep   = 6'(BAR_STEP);
    localparam logic [5:0]  BarMax    = 6'(BAR_MAX);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS - 1);

    seq_state_e       state_q;
    logic [3:0]       target_q;
    logic [3:0]       screen_q;
    logic [3:0]       reveal_q;
    logic [5:0]       bar_q;
    logic [HoldW-1:0] hold_q;
    logic             busy_q;
    logic             done_q;

    logic       running;
    logic       idle;
    logic       tick;
    logic [3:0] reveal_nxt;
    logic [5:0] bar_sum;
    logic       grow;
    logic       go_done;

    assign running    = (state_q == StLoad) || (state_q == StHold);
    assign idle       = (state_q == StIdle);
    assign reveal_nxt = (reveal_q == RevealMax) ? 4'd0 : reveal_q + 4'd1;
    assign bar_sum    = bar_q + BarStep;
    // Bar grows on the tick that leaves a reveal step of the form 5k+4
    assign grow       = ((reveal_q % 4'd5) == 4'd4) && (bar_q < BarMax);
    // Skip takes priority over any tick in the same cycle
    assign go_done    = running &&
                        (bus.skip || ((state_q == StHold) && tick && (hold_q == HoldLast)));

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .clear (idle),
        .en    (running),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            target_q <= SCR_MENU;
            screen_q <= SCR_MENU;
            reveal_q <= '0;
            bar_q    <= '0;
            hold_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (go_done) begin
            state_q  <= StDone;
            screen_q <= target_q;
            reveal_q <= '0;
            bar_q    <= '0;
            done_q   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q  <= StLoad;
                        target_q <= bus.target;
                        screen_q <= SCR_LOADING;
                        reveal_q <= '0;
                        bar_q    <= '0;
                        hold_q   <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                StLoad: begin
                    if (tick) begin
                        reveal_q <= reveal_nxt;
                        if (grow) begin
                            bar_q <= bar_sum;
                            if (bar_sum == BarMax) begin
                                state_q <= StHold;
                            end
                        end
                    end
                end
                StHold: begin
                    if (tick) begin
                        reveal_q <= reveal_nxt;
                        hold_q   <= hold_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.screen  = screen_q;
    assign bus.reveal  = reveal_q;
    assign bus.bar_len = bar_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_loading_sequencer.sv
// Directed bench for loading_sequencer with TICK_DIV=4: a checkpoint table for
// the full sequence plus hand-written skip, idle and reset scenarios.
module tb_loading_sequencer;
    import screen_pkg::*;

    localparam int unsigned TD = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    loading_sequencer_if bus ();

    loading_sequencer #(
        .TICK_DIV   (TD),
        .REVEAL_MAX (9),
        .BAR_STEP   (12),
        .BAR_MAX    (60),
        .HOLD_TICKS (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;     // edges after the start edge
        logic [3:0] screen;
        logic [3:0] reveal;
        logic [5:0] bar_len;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[16];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] scr, input logic [3:0] rev,
                              input logic [5:0] bar, input logic bsy, input logic dn);
        check({name, ".screen"},  {4'b0, bus.screen},  {4'b0, scr});
        check({name, ".reveal"},  {4'b0, bus.reveal},  {4'b0, rev});
        check({name, ".bar_len"}, {2'b0, bus.bar_len}, {2'b0, bar});
        check({name, ".busy"},    {7'b0, bus.busy},    {7'b0, bsy});
        check({name, ".done"},    {7'b0, bus.done},    {7'b0, dn});
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int c);
        while (cyc < c) begin
            step();
            check("bar_bound",    {7'b0, (bus.bar_len <= 6'd60)}, 8'd1);
            check("reveal_bound", {7'b0, (bus.reveal <= 4'd9)},   8'd1);
        end
    endtask

    task automatic start_load(input logic [3:0] tgt, input logic with_skip);
        bus.start  = 1'b1;
        bus.target = tgt;
        bus.skip   = with_skip;
        step();
        cyc        = 0;
        bus.start  = 1'b0;
        bus.skip   = 1'b0;
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // cyc, screen, reveal, bar, busy, done
        vecs[0]  = '{0,   4'h6, 4'd0, 6'd0,  1'b1, 1'b0};
        vecs[1]  = '{3,   4'h6, 4'd0, 6'd0,  1'b1, 1'b0};
        vecs[2]  = '{4,   4'h6, 4'd1, 6'd0,  1'b1, 1'b0};
        vecs[3]  = '{12,  4'h6, 4'd3, 6'd0,  1'b1, 1'b0};
        vecs[4]  = '{16,  4'h6, 4'd4, 6'd0,  1'b1, 1'b0};
        vecs[5]  = '{20,  4'h6, 4'd5, 6'd12, 1'b1, 1'b0};
        vecs[6]  = '{36,  4'h6, 4'd9, 6'd12, 1'b1, 1'b0};
        vecs[7]  = '{40,  4'h6, 4'd0, 6'd24, 1'b1, 1'b0};
        vecs[8]  = '{60,  4'h6, 4'd5, 6'd36, 1'b1, 1'b0};
        vecs[9]  = '{80,  4'h6, 4'd0, 6'd48, 1'b1, 1'b0};
        vecs[10] = '{96,  4'h6, 4'd4, 6'd48, 1'b1, 1'b0};
        vecs[11] = '{100, 4'h6, 4'd5, 6'd60, 1'b1, 1'b0};
        vecs[12] = '{116, 4'h6, 4'd9, 6'd60, 1'b1, 1'b0};
        vecs[13] = '{119, 4'h6, 4'd9, 6'd60, 1'b1, 1'b0};
        vecs[14] = '{120, 4'h2, 4'd0, 6'd0,  1'b1, 1'b1};
        vecs[15] = '{121, 4'h2, 4'd0, 6'd0,  1'b0, 1'b0};

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.target = 4'h0;
        bus.skip   = 1'b0;
        repeat (3) step();
        check_outs("reset", 4'h0, 4'd0, 6'd0, 1'b0, 1'b0);
        reset = 1'b0;

        // Skip alone in IDLE does nothing
        bus.skip = 1'b1;
        step();
        bus.skip = 1'b0;
        check_outs("idle_skip", 4'h0, 4'd0, 6'd0, 1'b0, 1'b0);

        // Full sequence to target 2, with a second start (target 3) at tick 3
        start_load(4'h2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            advance_to(vecs[i].cyc);
            check_outs($sformatf("seq%0d", vecs[i].cyc), vecs[i].screen, vecs[i].reveal,
                       vecs[i].bar_len, vecs[i].busy, vecs[i].done);
            if (vecs[i].cyc == 12) begin
                bus.start  = 1'b1;
                bus.target = 4'h3;
                step();
                bus.start  = 1'b0;
            end
        end

        // Start and skip together in IDLE: start wins
        start_load(4'h5, 1'b1);
        check_outs("startskip", 4'h6, 4'd0, 6'd0, 1'b1, 1'b0);
        step();
        check_outs("startskip+1", 4'h6, 4'd0, 6'd0, 1'b1, 1'b0);
        advance_to(47);
        check_outs("pre_skip", 4'h6, 4'd1, 6'd24, 1'b1, 1'b0);
        // Skip lands on the tick-12 edge: skip wins
        bus.skip = 1'b1;
        step();
        bus.skip = 1'b0;
        check_outs("skip_done", 4'h5, 4'd0, 6'd0, 1'b1, 1'b1);
        step();
        check_outs("skip_idle", 4'h5, 4'd0, 6'd0, 1'b0, 1'b0);

        // Reset mid-operation at tick 17
        start_load(4'h4, 1'b0);
        advance_to(68);
        check_outs("pre_reset", 4'h6, 4'd7, 6'd36, 1'b1, 1'b0);
        reset = 1'b1;
        step();
        check_outs("mid_reset", 4'h0, 4'd0, 6'd0, 1'b0, 1'b0);
        reset = 1'b0;
        advance_to(cyc + 8);
        check_outs("post_reset", 4'h0, 4'd0, 6'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
